spi_burst_ctrl: RTL
===================

// Module: spi_burst_ctrl
// PURPOSE
//  Parametrised SPI transaction sequencer; next generation of the single-byte SPI control FSM.
//  On a send request it runs a burst of 1..DEPTH words through the SPI shift engine:
//  - reads each TX word from the data register file;
//  - writes each RX word back to the same address.
//  At the end it writes back the control register (clears send, reports the received count).
//  Sits between the control/data register files and the SPI shifter + SCLK generator.
// PARAMETERS
//  DATA_W   8     width of one SPI word (TX/RX)
//  DEPTH    16    data register file entries; max words per burst (power of 2, >=2)
//  TOUT_CYC 1024  max cycles waiting for done_i (used only with SPI_BURST_TOUT_EN)
//  AW = $clog2(DEPTH) (localparam)
// PORTS
//  clk_i        in   1       system clock
//  rst_ni       in   1       asynchronous reset, active low
//  send_i       in   1       control reg send bit; burst request
//  n_tx_end_i   in   AW      words in burst minus 1 (0 -> 1 word, DEPTH-1 -> DEPTH words)
//  all_ones_i   in   1       1: transmit all-ones words instead of register file data
//  rd_addr_o    out  AW      data reg file read address (read data valid next cycle)
//  rd_data_i    in   DATA_W  data reg file read data
//  tx_data_o    out  DATA_W  word to shifter, held stable from start_o until done_i
//  start_o      out  1       1-cycle pulse: shifter begins one word
//  done_i       in   1       1-cycle pulse from shifter: word complete, rx_data_i valid
//  rx_data_i    in   DATA_W  received word
//  wr_en_o      out  1       data reg file write strobe (1 cycle)
//  wr_addr_o    out  AW      write address
//  wr_data_o    out  DATA_W  write data (= captured rx word)
//  ctrl_we_o    out  1       control reg write-back strobe (1 cycle)
//  ctrl_send_o  out  1       value for send bit on write-back (always 0)
//  ctrl_n_rx_o  out  AW+1    words received in the burst, for write-back
//  cs_no        out  1       slave chip select, active low
//  busy_o       out  1       high from leaving IDLE until return to IDLE
//  err_o        out  1       timeout flag (tied 0 without SPI_BURST_TOUT_EN)
// BEHAVIOUR
//  Reset (async, rst_ni=0):
//  - state=IDLE, word counter=0; all outputs 0 except cs_no=1;
//  - tx_data_o and ctrl_n_rx_o are 0.
//  States:
//  - IDLE: cs_no=1. If send_i=1 then cnt<=0 and go to LOAD.
//  - LOAD: rd_addr_o=cnt for one cycle; go to START.
//  - START: tx_data_o<=all_ones_i ? '1 : rd_data_i; cs_no=0; start_o=1; go to WAIT.
//  - WAIT: hold tx_data_o and cs_no=0. On done_i, capture rx_data_i and go to STORE.
//  - STORE: wr_en_o=1, wr_addr_o=cnt, wr_data_o=captured word.
//    If cnt==n_tx_end_i go to FIN; else cnt<=cnt+1 and go to LOAD.
//  - FIN: ctrl_we_o=1, ctrl_send_o=0, ctrl_n_rx_o=cnt+1 (AW+1 bits, no wrap); cs_no=1; go to IDLE.
//  Latency:
//  - send_i in IDLE -> start_o asserted 2 cycles later;
//  - done_i -> next start_o 3 cycles later;
//  - last done_i -> ctrl_we_o 2 cycles later.
//  Boundary and simultaneous events:
//  - n_tx_end_i and all_ones_i are sampled once, on leaving IDLE; later changes are ignored.
//  - send_i dropping mid-burst is ignored; the burst completes.
//  - send_i still high in the cycle after FIN starts a new burst (the write-back clears it in the register).
//  - done_i outside WAIT is ignored.
//  - cs_no stays low continuously across all words of the burst.
//  - n_tx_end_i=DEPTH-1: all DEPTH words are used; cnt never wraps; ctrl_n_rx_o=DEPTH.
//  - Reset mid-burst: immediate abort, outputs to reset values; no partial write-back.
// CONFIGURATION
//  SPI_BURST_TOUT_EN defined:
//  - A cycle counter runs in WAIT.
//  - If done_i has not arrived after TOUT_CYC cycles: go to FIN with ctrl_n_rx_o = words completed (cnt).
//  - err_o is set and stays 1 until the next accepted send_i.
//  SPI_BURST_TOUT_EN undefined:
//  - No timeout counter; WAIT lasts until done_i.
//  - err_o is constant 0 and TOUT_CYC is unused.
// TESTING
//  1. Reset: rst_ni=0 with send_i=1 -> cs_no=1, busy_o=0, start_o=0, no strobes.
//  2. n_tx_end_i=0, reg[0]=8'hA5, shifter returns 8'h3C
//     -> tx_data_o=A5; reg[0]<=3C; ctrl_we_o with ctrl_n_rx_o=1; exactly one start_o.
//  3. n_tx_end_i=15, all_ones_i=1, DEPTH=16
//     -> 16 start_o pulses, each tx_data_o=FF; wr_addr_o 0..15; ctrl_n_rx_o=16; cs_no low throughout.
//  4. Drop send_i after the 1st word; inject spurious done_i in LOAD -> burst still completes; spurious done_i ignored.
//  5. Assert rst_ni=0 during WAIT of word 2 of 4 -> cs_no=1 next edge; no ctrl_we_o; new send_i restarts at addr 0.
//  6. SPI_BURST_TOUT_EN, TOUT_CYC=16, withhold done_i on word 3
//     -> after 16 cycles: ctrl_we_o with ctrl_n_rx_o=2, err_o=1; err_o clears on next send_i.

Source files
------------

// File: rtl/spi_burst_ctrl.sv
// SPI burst sequencer: streams 1..DEPTH words from the data register file through the shifter,
// writes each received word back in place and then writes back the control register.
// Optional read-back timeout is enabled by defining SPI_BURST_TOUT_EN.
module spi_burst_ctrl #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int TOUT_CYC = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     send_i,
    input  logic [$clog2(DEPTH)-1:0] n_tx_end_i,
    input  logic                     all_ones_i,
    output logic [$clog2(DEPTH)-1:0] rd_addr_o,
    input  logic [DATA_W-1:0]        rd_data_i,
    output logic [DATA_W-1:0]        tx_data_o,
    output logic                     start_o,
    input  logic                     done_i,
    input  logic [DATA_W-1:0]        rx_data_i,
    output logic                     wr_en_o,
    output logic [$clog2(DEPTH)-1:0] wr_addr_o,
    output logic [DATA_W-1:0]        wr_data_o,
    output logic                     ctrl_we_o,
    output logic                     ctrl_send_o,
    output logic [$clog2(DEPTH):0]   ctrl_n_rx_o,
    output logic                     cs_no,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STORE, FIN} state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt;
    logic [AW-1:0]     n_end;
    logic              ones;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [AW:0]       n_rx;
    logic              tout_hit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // tx word is driven straight from the read port during START so it is valid with start_o
    always_comb begin
        state_nxt = state;
        start_o   = 1'b0;
        wr_en_o   = 1'b0;
        ctrl_we_o = 1'b0;
        cs_no     = 1'b1;
        tx_data_o = tx_q;
        case (state)
            IDLE: begin
                if (send_i) state_nxt = LOAD;
            end
            LOAD: begin
                cs_no     = (cnt == '0);
                state_nxt = START;
            end
            START: begin
                cs_no     = 1'b0;
                start_o   = 1'b1;
                tx_data_o = ones ? '1 : rd_data_i;
                state_nxt = WAIT;
            end
            WAIT: begin
                cs_no = 1'b0;
                if (done_i)        state_nxt = STORE;
                else if (tout_hit) state_nxt = FIN;
            end
            STORE: begin
                cs_no     = 1'b0;
                wr_en_o   = 1'b1;
                state_nxt = (cnt == n_end) ? FIN : LOAD;
            end
            FIN: begin
                ctrl_we_o = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            n_end <= '0;
            ones  <= 1'b0;
            tx_q  <= '0;
            rx_q  <= '0;
            n_rx  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (send_i) begin
                        cnt   <= '0;
                        n_end <= n_tx_end_i;
                        ones  <= all_ones_i;
                    end
                end
                START: tx_q <= tx_data_o;
                WAIT: begin
                    if (done_i)        rx_q <= rx_data_i;
                    else if (tout_hit) n_rx <= {1'b0, cnt};
                end
                STORE: begin
                    // count is widened by one bit so a full DEPTH-word burst reports DEPTH
                    if (cnt == n_end) n_rx <= {1'b0, cnt} + (AW+1)'(1);
                    else              cnt  <= cnt + AW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SPI_BURST_TOUT_EN
    localparam int TW = $clog2(TOUT_CYC + 1);

    logic [TW-1:0] tout_cnt;
    logic          err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tout_cnt <= '0;
            err      <= 1'b0;
        end else begin
            tout_cnt <= (state == WAIT) ? tout_cnt + TW'(1) : '0;
            if (state == IDLE && send_i)              err <= 1'b0;
            else if (state == WAIT && !done_i && tout_hit) err <= 1'b1;
        end
    end

    assign tout_hit = (state == WAIT) && (tout_cnt == TW'(TOUT_CYC - 1));
    assign err_o    = err;
`else
    assign tout_hit = 1'b0;
    assign err_o    = 1'b0;
`endif

    assign rd_addr_o   = cnt;
    assign wr_addr_o   = cnt;
    assign wr_data_o   = rx_q;
    assign ctrl_send_o = 1'b0;
    assign ctrl_n_rx_o = n_rx;
    assign busy_o      = (state != IDLE);

endmodule
